// File: rtl/mips_instr_encoder_pkg.sv
// Shared MIPS single-cycle definitions: opcode type, funct codes, encoder
// FSM states and the encoder FIFO depth.
package mips_instr_encoder_pkg;

    // Primary opcodes understood by the encoder (instruction bits [31:26]).
    typedef enum logic [5:0] {
        OP_R_TYPE = 6'h00,
        OP_J      = 6'h02,
        OP_BEQ    = 6'h04,
        OP_ADDI   = 6'h08,
        OP_LW     = 6'h23,
        OP_SW     = 6'h2B
    } opcode_t;

    // R-type function codes (instruction bits [5:0]).
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // Encoder control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } enc_state_t;

    // Number of encoded words buffered ahead of the memory write port.
    localparam int ENC_FIFO_DEPTH = 4;

    // True when an R-type funct belongs to the supported ALU subset.
    function automatic logic funct_supported(input logic [5:0] funct);
        return (funct == FUNCT_ADD) || (funct == FUNCT_SUB) ||
               (funct == FUNCT_AND) || (funct == FUNCT_OR)  ||
               (funct == FUNCT_SLT);
    endfunction

endpackage

// File: rtl/mips_enc_fifo.sv
// Small synchronous FIFO for encoded instruction words. A push while full is
// accepted only when a pop happens in the same cycle, so occupancy stays put.
module mips_enc_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    occ_q, occ_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full     = (occ_q == CW'(DEPTH));
    assign empty    = (occ_q == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q];

    // Next pointer and occupancy values from this cycle's push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (do_push && !do_pop)      occ_d = occ_q + CW'(1);
        else if (!do_push && do_pop) occ_d = occ_q - CW'(1);
    end

    // Pointer/occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage array; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// MIPS instruction encoder: accepts instruction descriptors, encodes them into
// 32-bit words and streams them into instruction memory from base_addr upward.
// Build option: define MIPS_ENC_FUNCT_CHECK_EN to reject R-type instructions
// whose funct is outside {add, sub, and, or, slt}.
//
// Handshakes: a descriptor transfers on a rising edge where in_valid and
// in_ready are both 1; in_ready never depends on in_valid. A memory write
// transfers on a rising edge where mem_we and mem_ready are both 1; mem_we
// never depends on mem_ready. in_ready is also 1 when the FIFO is full but the
// head is leaving this cycle, so push and pop can share a full cycle.
module mips_instr_encoder
    import mips_instr_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  opcode_t     in_opcode,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [5:0]  in_funct,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] count,
    output enc_state_t  dbg_state
);

    enc_state_t  state_q, state_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [15:0] count_q, count_d;
    logic        err_q, err_d;
    logic        done_q, done_d;

    logic [31:0] enc_word;
    logic        enc_ok;
    logic        in_hs;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;

    // Combinational encoding of the presented descriptor.
    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b0;
        case (in_opcode)
            OP_R_TYPE: begin
                enc_word = {in_opcode, in_rs, in_rt, in_rd, in_shamt, in_funct};
`ifdef MIPS_ENC_FUNCT_CHECK_EN
                enc_ok   = funct_supported(in_funct);
`else
                enc_ok   = 1'b1;
`endif
            end
            OP_LW, OP_SW, OP_BEQ, OP_ADDI: begin
                enc_word = {in_opcode, in_rs, in_rt, in_imm};
                enc_ok   = 1'b1;
            end
            OP_J: begin
                enc_word = {in_opcode, in_target};
                enc_ok   = 1'b1;
            end
            default: begin
                enc_word = '0;
                enc_ok   = 1'b0;
            end
        endcase
    end

    assign mem_we    = !fifo_empty;
    assign fifo_pop  = mem_we && mem_ready;
    assign in_ready  = (state_q == ST_RUN) && (!fifo_full || fifo_pop);
    assign in_hs     = in_valid && in_ready;
    assign fifo_push = in_hs && enc_ok;

    mips_enc_fifo #(
        .WIDTH (32),
        .DEPTH (ENC_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (enc_word),
        .pop       (fifo_pop),
        .pop_data  (mem_wdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state, address, counter and status computation.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        count_d    = count_q;
        err_d      = err_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    mem_addr_d = base_addr;
                    count_d    = '0;
                    err_d      = 1'b0;
                end
            end
            ST_RUN: begin
                // The descriptor accepted alongside stop is still pushed.
                if (stop) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Pops only occur outside IDLE, so they never collide with a start load.
        if (fifo_pop) begin
            mem_addr_d = mem_addr_q + 32'd4;
            count_d    = count_q + 16'd1;
        end
        if (in_hs && !enc_ok) err_d = 1'b1;
    end

    // Control registers; reset returns to IDLE with all status cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mem_addr_q <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            count_q    <= count_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign count     = count_q;
    assign err       = err_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule
